// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;

  localparam int BYTES_PER_WORD = 4;

  // Byte-counter value at which the current byte completes a word.
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words. The word and its strobe
// are presented in the same cycle as the completing byte, so the loader can
// register the write on that edge and show it one cycle after acceptance.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  data,
  input  logic        accept,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // Shift in accepted bytes and count position within the word.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      shift_q <= {shift_q[15:0], data};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  assign word       = {shift_q, data};
  assign word_valid = accept && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed, checksummed program image into instruction
// memory and holds the CPU in reset until the image verifies.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [31:0] words_loaded
);

  state_t      state_q, state_d;
  logic [31:0] len_q;
  logic [31:0] csum_q;
  logic        accept;
  logic        reload_take;
  logic [31:0] word;
  logic        word_valid;

  assign accept      = in_valid && in_ready;
  assign reload_take = reload && (state_q == S_DONE || state_q == S_ERR);

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (reload_take),
    .data       (in_data),
    .accept     (accept),
    .word       (word),
    .word_valid (word_valid)
  );

  // Next-state decision on each completed word or a reload request.
  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN: if (word_valid) begin
        if (word == 32'd0)                 state_d = S_CSUM;
        else if (word > 32'(MEM_DEPTH))    state_d = S_ERR;
        else                               state_d = S_DATA;
      end
      S_DATA: if (word_valid && (words_loaded + 32'd1 == len_q)) state_d = S_CSUM;
      S_CSUM: if (word_valid) state_d = (word == csum_q) ? S_DONE : S_ERR;
      S_DONE, S_ERR: if (reload) state_d = S_LEN;
      default: state_d = S_LEN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LEN;
    else       state_q <= state_d;
  end

  // Registered outputs, memory write port, counters and checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      err_code     <= ERR_NONE;
      words_loaded <= '0;
      csum_q       <= '0;
      len_q        <= '0;
    end else begin
      in_ready <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      imem_we  <= 1'b0;
      case (state_q)
        S_LEN: if (word_valid) begin
          len_q <= word;
          if (word > 32'(MEM_DEPTH)) err_code <= ERR_LEN;
        end
        S_DATA: if (word_valid) begin
          imem_we      <= 1'b1;
          imem_addr    <= {words_loaded[29:0], 2'b00};
          imem_wdata   <= word;
          words_loaded <= words_loaded + 32'd1;
          csum_q       <= csum_q + word;
        end
        S_CSUM: if (word_valid) begin
          if (word == csum_q) begin
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            err_code  <= ERR_CSUM;
          end
        end
        S_DONE, S_ERR: if (reload) begin
          cpu_reset    <= 1'b1;
          done         <= 1'b0;
          err_code     <= ERR_NONE;
          words_loaded <= '0;
          csum_q       <= '0;
          len_q        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle CPU's instruction ROM.
- Receives a program image as a byte stream with a valid/ready handshake, assembles big-endian 32-bit words, writes them to instruction memory from address 0, and verifies a trailing checksum.
- Holds the CPU in reset until a load completes successfully, then releases it.

Parameters:
- MEM_DEPTH, 1024, instruction memory depth in 32-bit words; maximum accepted program length.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte
- reload  input  1  one-cycle pulse; restarts loading from DONE or ERR
- imem_we  output  1  instruction memory write strobe
- imem_addr  output  32  byte address of write, word aligned
- imem_wdata  output  32  word to write
- cpu_reset  output  1  drives the CPU reset; high while not DONE
- done  output  1  image loaded and checksum matched
- err_code  output  2  0 none, 1 length > MEM_DEPTH, 2 checksum mismatch
- words_loaded  output  32  count of data words written

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = S_LEN, in_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - cpu_reset = 1, done = 0, err_code = 0, words_loaded = 0, byte counter = 0, checksum accumulator = 0.
- Reset mid-load: returns to the values above. Memory contents are not cleared.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready = 1 in S_LEN, S_DATA and S_CSUM; 0 in S_DONE and S_ERR.
  - in_data is ignored when not accepted.
- Byte packing: the first accepted byte of each word is bits 31:24, and so on down to bits 7:0. A 2-bit byte counter wraps 3 -> 0 on the 4th byte.
- States (enum in package):
  - S_LEN: collect 4 bytes into N.
    - On the 4th byte: N == 0 -> S_CSUM; N > MEM_DEPTH -> S_ERR with err_code = 1; otherwise -> S_DATA.
  - S_DATA: on the 4th byte of each word, in the following cycle: imem_we = 1 for exactly one cycle, imem_addr = words_loaded*4, imem_wdata = word.
    - Same edge: words_loaded += 1, checksum += word (mod 2^32).
    - When words_loaded reaches N -> S_CSUM.
    - Back-to-back bytes are legal; the minimum word spacing is 4 cycles, so strobes never overlap.
  - S_CSUM: collect 4 bytes.
    - Equal to the accumulator -> S_DONE: done = 1, cpu_reset = 0 from the next cycle.
    - Not equal -> S_ERR: err_code = 2, cpu_reset stays 1.
  - S_DONE / S_ERR: hold all outputs.
    - reload = 1 -> S_LEN: cpu_reset = 1, done = 0, err_code = 0, counters and accumulator cleared, in_ready = 1 from the next cycle.
- Simultaneous events:
  - reload outside S_DONE/S_ERR is ignored.
  - reset has priority over reload and over a byte accept on the same edge.
- Arithmetic:
  - imem_addr is {words_loaded[29:0], 2'b00}.
  - The checksum wraps mod 2^32; the carry is discarded.
  - N == MEM_DEPTH is legal and the last write goes to address (MEM_DEPTH-1)*4.
- Latency: last byte of a word accepted -> imem_we asserted in the next cycle. Last checksum byte accepted -> done/cpu_reset updated in the next cycle.

Decomposition:
- Package imem_loader_pkg:
  - state enum (S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR).
  - err_code constants (ERR_NONE, ERR_LEN, ERR_CSUM).
  - BYTES_PER_WORD = 4.
- Sub-module word_assembler: byte shift register plus 2-bit counter. Inputs are a byte and an accept strobe; outputs are a 32-bit word and a one-cycle word_valid. It is cleared by reset and by reload.
- The FSM, address and word counter, and checksum stay in imem_boot_loader.

Test Plan:
- Happy path, N = 2:
  - Stimulus: stream 00 00 00 02, 20 08 00 05, 00 00 00 00, checksum 20 08 00 05, one byte per cycle.
  - Response: writes (0x0, 0x20080005) then (0x4, 0x00000000); done = 1, cpu_reset = 0, err_code = 0, words_loaded = 2.
- Stalled stream:
  - Stimulus: same image with in_valid low for 3 cycles between every byte.
  - Response: identical writes; imem_we pulses exactly twice, each 1 cycle wide.
- Checksum mismatch:
  - Stimulus: N = 1, word 0x00000001, checksum 0x00000002.
  - Response: one write at 0x0; err_code = 2, cpu_reset = 1, in_ready = 0.
  - Then pulse reload and send a good image: err_code = 0, done = 1.
- Length limits:
  - Stimulus: MEM_DEPTH = 4, N = 5.
  - Response: err_code = 1 immediately after the 4th length byte; no imem_we.
  - Stimulus: N = 4 with 4 words summing to 0x1_0000_0003, checksum 0x00000003.
  - Response: done = 1, last address 0xC.
- Zero length:
  - Stimulus: N = 0, checksum 00 00 00 00.
  - Response: no writes; done = 1, cpu_reset = 0.
- Reset mid-load:
  - Stimulus: assert reset after 2 of 4 bytes of the first data word, then send a full N = 1 image.
  - Response: no stale write; the write lands at 0x0 with the new word; done = 1.
